wb_regfile: RTL and testbench

- Next-generation write-back plus register file for the RISC datapath, replacing the fixed 16-bit, 8-register combinational write-back.
- Selects one of NSRC write-back sources, registers the write for one cycle, then commits it to a parametrised register file.
- Provides two combinational read ports with forwarding of the pending write, and a per-register busy scoreboard used by the controller FSM for hazard stalls.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_src_mux.sv | 28 ++
 rtl/wb_regfile.sv | 127 ++++++++++++
 tb/tb_wb_regfile.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants for the write-back / register file slice: source-select
// encodings and the default datapath geometry.
package wb_pkg;

   localparam int VSEL_MEM = 0;
   localparam int VSEL_ALU = 1;
   localparam int VSEL_IMM = 2;
   localparam int VSEL_PC  = 3;

   localparam int WB_DATA_W = 16;
   localparam int WB_NREGS  = 8;

endpackage

// File: rtl/wb_src_mux.sv
// NSRC:1 write-back source mux. Source k sits at bits [k*DATA_W +: DATA_W]
// of the flattened bus; oor flags a select that names no source.
module wb_src_mux
   import wb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int NSRC   = 4,
   parameter int SEL_W  = $clog2(NSRC)
) (
   input  logic [SEL_W-1:0]       sel,
   input  logic [NSRC*DATA_W-1:0] src,
   output logic [DATA_W-1:0]      dout,
   output logic                   oor
);

   // Select the addressed source; an unmatched select yields zero and raises oor
   always_comb begin
      dout = '0;
      oor  = 1'b1;
      for (int k = 0; k < NSRC; k++) begin
         if (int'(sel) == k) begin
            dout = src[k*DATA_W +: DATA_W];
            oor  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus register file. A write is captured one edge after
// wb_valid (stage P) and committed to the array on the following edge
// (stage C); the captured write is forwarded to both read ports meanwhile.
// A busy scoreboard tracks claimed destinations for controller stalls.
// Optional build macro: WB_ZERO_R0_EN makes r0 a hard-wired zero register.
module wb_regfile
   import wb_pkg::*;
#(
   parameter int  DATA_W = WB_DATA_W,
   parameter int  NREGS  = WB_NREGS,
   parameter int  NSRC   = 4,
   localparam int ADDR_W = $clog2(NREGS),
   localparam int SEL_W  = $clog2(NSRC)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wb_valid,
   input  logic [SEL_W-1:0]       wb_vsel,
   input  logic [ADDR_W-1:0]      wb_writenum,
   input  logic [NSRC*DATA_W-1:0] wb_src,
   input  logic [ADDR_W-1:0]      readnum_a,
   input  logic [ADDR_W-1:0]      readnum_b,
   output logic [DATA_W-1:0]      data_a,
   output logic [DATA_W-1:0]      data_b,
   input  logic                   claim_valid,
   input  logic [ADDR_W-1:0]      claim_num,
   output logic [NREGS-1:0]       busy,
   output logic                   err
);

   logic [DATA_W-1:0] mux_data;
   logic              mux_oor;
   logic              capture_ok;
   logic              claim_ok;
   logic [NREGS-1:0]  busy_nxt;

   logic              vld_p1;
   logic [ADDR_W-1:0] num_p1;
   logic [DATA_W-1:0] data_p1;

   logic [DATA_W-1:0] regs [NREGS];

   wb_src_mux #(
      .DATA_W (DATA_W),
      .NSRC   (NSRC),
      .SEL_W  (SEL_W)
   ) u_src_mux (
      .sel  (wb_vsel),
      .src  (wb_src),
      .dout (mux_data),
      .oor  (mux_oor)
   );

   // Decide whether this cycle's request is captured and whether a claim is honoured
   always_comb begin
      capture_ok = wb_valid & ~mux_oor;
      claim_ok   = claim_valid;
`ifdef WB_ZERO_R0_EN
      if (wb_writenum == '0) capture_ok = 1'b0;
      if (claim_num == '0)   claim_ok   = 1'b0;
`endif
   end

   // ---- stage P: capture selected source into the pending write ----
   // Pending-write register; a dropped request simply leaves vld_p1 low
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         num_p1  <= '0;
         data_p1 <= '0;
      end else begin
         vld_p1 <= capture_ok;
         if (capture_ok) begin
            num_p1  <= wb_writenum;
            data_p1 <= mux_data;
         end
      end
   end

   // Sticky flag for a write-back request whose select names no source
   always_ff @(posedge clk) begin
      if (!rst_n)                   err <= 1'b0;
      else if (wb_valid && mux_oor) err <= 1'b1;
   end

   // ---- stage C: commit pending write to the architectural array ----
   // Register array; reset clears it and discards any pending write
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (vld_p1) begin
         regs[num_p1] <= data_p1;
      end
   end

   // Scoreboard next state: commit clears, claim sets afterwards so a same-cycle claim wins
   always_comb begin
      busy_nxt = busy;
      if (vld_p1)   busy_nxt[num_p1]    = 1'b0;
      if (claim_ok) busy_nxt[claim_num] = 1'b1;
   end

   // Scoreboard state register
   always_ff @(posedge clk) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_nxt;
   end

   // Read port A: array value, overridden by the newer pending write
   always_comb begin
      data_a = regs[readnum_a];
      if (vld_p1 && (num_p1 == readnum_a)) data_a = data_p1;
`ifdef WB_ZERO_R0_EN
      if (readnum_a == '0) data_a = '0;
`endif
   end

   // Read port B: identical forwarding rule to port A
   always_comb begin
      data_b = regs[readnum_b];
      if (vld_p1 && (num_p1 == readnum_b)) data_b = data_p1;
`ifdef WB_ZERO_R0_EN
      if (readnum_b == '0) data_b = '0;
`endif
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile, built with three sources so that select 3
// is out of range. The driver queues hand-computed expectations; a monitor
// on the falling edge pops and compares them against the DUT outputs.
module tb_wb_regfile;

   localparam int DATA_W = 16;
   localparam int NREGS  = 8;
   localparam int NSRC   = 3;
   localparam int ADDR_W = 3;
   localparam int SEL_W  = 2;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   wb_valid;
   logic [SEL_W-1:0]       wb_vsel;
   logic [ADDR_W-1:0]      wb_writenum;
   logic [NSRC*DATA_W-1:0] wb_src;
   logic [ADDR_W-1:0]      readnum_a;
   logic [ADDR_W-1:0]      readnum_b;
   logic [DATA_W-1:0]      data_a;
   logic [DATA_W-1:0]      data_b;
   logic                   claim_valid;
   logic [ADDR_W-1:0]      claim_num;
   logic [NREGS-1:0]       busy;
   logic                   err;

   always #5 clk = ~clk;

   wb_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .NSRC   (NSRC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wb_valid    (wb_valid),
      .wb_vsel     (wb_vsel),
      .wb_writenum (wb_writenum),
      .wb_src      (wb_src),
      .readnum_a   (readnum_a),
      .readnum_b   (readnum_b),
      .data_a      (data_a),
      .data_b      (data_b),
      .claim_valid (claim_valid),
      .claim_num   (claim_num),
      .busy        (busy),
      .err         (err)
   );

   typedef struct {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [NREGS-1:0]  bz;
      logic              e;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    total = 0;
   int    bad   = 0;
   bit    chk_req = 1'b0;

   task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
      end
   endtask

   // Monitor: whenever the driver flags an observation, pop and compare
   always @(negedge clk) begin : monitor
      exp_t  x;
      string nm;
      if (chk_req) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_underflow actual=empty required=entry");
         end else begin
            x  = exp_q.pop_front();
            nm = name_q.pop_front();
            cmp(nm, "data_a", 32'(data_a), 32'(x.a));
            cmp(nm, "data_b", 32'(data_b), 32'(x.b));
            cmp(nm, "busy",   32'(busy),   32'(x.bz));
            cmp(nm, "err",    32'(err),    32'(x.e));
         end
      end
   end

   task automatic expect_now(input string nm, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                             input logic [NREGS-1:0] bz, input logic e);
      exp_t x;
      x.a = a; x.b = b; x.bz = bz; x.e = e;
      exp_q.push_back(x);
      name_q.push_back(nm);
      chk_req = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      chk_req     = 1'b0;
      wb_valid    = 1'b0;
      claim_valid = 1'b0;
   endtask

   task automatic wb(input int sel, input int num, input logic [DATA_W-1:0] val);
      wb_valid    = 1'b1;
      wb_vsel     = SEL_W'(sel);
      wb_writenum = ADDR_W'(num);
      wb_src      = '0;
      if (sel < NSRC) wb_src[sel*DATA_W +: DATA_W] = val;
   endtask

   task automatic claim(input int num);
      claim_valid = 1'b1;
      claim_num   = ADDR_W'(num);
   endtask

   initial begin
      rst_n = 1'b0; wb_valid = 1'b0; wb_vsel = '0; wb_writenum = '0; wb_src = '0;
      readnum_a = '0; readnum_b = '0; claim_valid = 1'b0; claim_num = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // reset state on every register
      for (int i = 0; i < NREGS; i++) begin
         readnum_a = ADDR_W'(i);
         readnum_b = ADDR_W'(NREGS - 1 - i);
         expect_now("reset_rd", 16'h0, 16'h0, 8'h00, 1'b0);
         tick();
      end

      // ALU source to r3: forwarded after one edge, architectural after two
      wb(1, 3, 16'hBEEF); readnum_a = 3; readnum_b = 4;
      expect_now("no_same_cycle_fwd", 16'h0, 16'h0, 8'h00, 1'b0); tick();
      readnum_b = 3;
      expect_now("fwd_r3", 16'hBEEF, 16'hBEEF, 8'h00, 1'b0); tick();
      expect_now("reg_r3", 16'hBEEF, 16'hBEEF, 8'h00, 1'b0); tick();

      // back-to-back writes to r5
      readnum_a = 5; readnum_b = 4;
      wb(0, 5, 16'h0001);
      expect_now("r5_pre", 16'h0, 16'h0, 8'h00, 1'b0); tick();
      wb(0, 5, 16'h0002);
      expect_now("r5_first", 16'h0001, 16'h0, 8'h00, 1'b0); tick();
      expect_now("r5_second", 16'h0002, 16'h0, 8'h00, 1'b0); tick();
      expect_now("r5_stable", 16'h0002, 16'h0, 8'h00, 1'b0); tick();

      // scoreboard on r2
      readnum_a = 2;
      claim(2);
      expect_now("claim_pre", 16'h0, 16'h0, 8'h00, 1'b0); tick();
      wb(2, 2, 16'h00AA);
      expect_now("claim_set", 16'h0, 16'h0, 8'h04, 1'b0); tick();
      claim(2);
      expect_now("claim_fwd", 16'h00AA, 16'h0, 8'h04, 1'b0); tick();
      wb(0, 2, 16'h0055);
      expect_now("claim_wins", 16'h00AA, 16'h0, 8'h04, 1'b0); tick();
      expect_now("commit_pend", 16'h0055, 16'h0, 8'h04, 1'b0); tick();
      expect_now("commit_clear", 16'h0055, 16'h0, 8'h00, 1'b0); tick();
      wb(1, 2, 16'h0066);
      expect_now("nonbusy_pre", 16'h0055, 16'h0, 8'h00, 1'b0); tick();
      expect_now("nonbusy_fwd", 16'h0066, 16'h0, 8'h00, 1'b0); tick();
      expect_now("nonbusy_commit", 16'h0066, 16'h0, 8'h00, 1'b0); tick();

      // double claim on r1 is cleared by a single commit
      readnum_a = 1;
      claim(1);
      expect_now("dup_pre", 16'h0, 16'h0, 8'h00, 1'b0); tick();
      claim(1);
      expect_now("dup_first", 16'h0, 16'h0, 8'h02, 1'b0); tick();
      wb(1, 1, 16'h1111);
      expect_now("dup_second", 16'h0, 16'h0, 8'h02, 1'b0); tick();
      expect_now("dup_pend", 16'h1111, 16'h0, 8'h02, 1'b0); tick();
      expect_now("dup_clear", 16'h1111, 16'h0, 8'h00, 1'b0); tick();

      // out-of-range select: no write, sticky error
      readnum_a = 7;
      wb(3, 7, 16'h7777);
      expect_now("oor_pre", 16'h0, 16'h0, 8'h00, 1'b0); tick();
      expect_now("oor_err", 16'h0, 16'h0, 8'h00, 1'b1); tick();
      expect_now("oor_sticky", 16'h0, 16'h0, 8'h00, 1'b1); tick();

      // reset while a write to r6 is pending
      readnum_a = 6; readnum_b = 3;
      wb(1, 6, 16'h1234); claim(4);
      expect_now("rst_pre", 16'h0, 16'hBEEF, 8'h00, 1'b1); tick();
      rst_n = 1'b0;
      expect_now("rst_fwd", 16'h1234, 16'hBEEF, 8'h10, 1'b1); tick();
      rst_n = 1'b1;
      expect_now("rst_clear", 16'h0, 16'h0, 8'h00, 1'b0); tick();
      expect_now("rst_dropped", 16'h0, 16'h0, 8'h00, 1'b0); tick();

      // register 0 behaviour
      readnum_a = 0; readnum_b = 4;
      wb(0, 0, 16'hFFFF); claim(0);
      expect_now("r0_pre", 16'h0, 16'h0, 8'h00, 1'b0); tick();
`ifdef WB_ZERO_R0_EN
      expect_now("r0_fwd", 16'h0, 16'h0, 8'h00, 1'b0); tick();
      expect_now("r0_reg", 16'h0, 16'h0, 8'h00, 1'b0); tick();
`else
      expect_now("r0_fwd", 16'hFFFF, 16'h0, 8'h01, 1'b0); tick();
      expect_now("r0_reg", 16'hFFFF, 16'h0, 8'h00, 1'b0); tick();
`endif

      tick();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
